// File: rtl/contador_regressivo_pkg.sv
// Shared types for the countdown timer and the alarm controller: FSM states,
// BCD digit type and small BCD helpers.
package contador_regressivo_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic logic [6:0] bcd_value(input bcd_t t, input bcd_t u);
    return 7'(t) * 7'd10 + 7'(u);
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One decade of a BCD down counter: parallel load, decrement with 0 -> 9 wrap,
// and a borrow flag for the next more-significant digit.
module bcd_digit_dec
  import contador_regressivo_pkg::*;
#(
  parameter bcd_t RST_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic [3:0] nxt,
  output logic       borrow
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign nxt    = q_d;
  assign borrow = en && (q_q == 4'd0);

endmodule

// File: rtl/contador_regressivo.sv
// Two-digit BCD countdown timer for the exit/entry delay: preset registers,
// IDLE/RUN/HOLD/DONE control, expiry pulse and final-seconds warning.
module contador_regressivo
  import contador_regressivo_pkg::*;
#(
  parameter bcd_t        DEF_TENS  = 4'd3,
  parameter bcd_t        DEF_UNITS = 4'd0,
  parameter int unsigned WARN_LIM  = 5
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_units,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       warn
);

  state_t state_q, state_d;
  bcd_t   pt_q, pt_d, pu_q, pu_d;
  logic   done_q, done_d, warn_q, warn_d;

  logic   ld_fsm, ld;
  bcd_t   ld_t_fsm, ld_u_fsm, ld_t, ld_u;
  logic   tick_en, u_borrow, t_borrow;
  bcd_t   tens_q, units_q, tens_nxt, units_nxt;
  bcd_t   pt_in, pu_in;
  logic   count_one, preset_zero_q;

  assign pt_in         = bcd_clamp(preset_tens);
  assign pu_in         = bcd_clamp(preset_units);
  assign count_one     = (tens_q == 4'd0) && (units_q == 4'd1);
  assign preset_zero_q = (pt_q == 4'd0) && (pu_q == 4'd0);
  assign tick_en       = (state_q == ST_RUN) && tick && !cancel && !pause;

  always_comb begin
    state_d  = state_q;
    pt_d     = pt_q;
    pu_d     = pu_q;
    ld_fsm   = 1'b0;
    ld_t_fsm = pt_q;
    ld_u_fsm = pu_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          pt_d     = pt_in;
          pu_d     = pu_in;
          ld_fsm   = 1'b1;
          ld_t_fsm = pt_in;
          ld_u_fsm = pu_in;
        end
        // A coincident load is honoured, so start sees the freshly loaded preset.
        if (!cancel && !pause && start) begin
          if ((pt_d == 4'd0) && (pu_d == 4'd0)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
          ld_fsm  = 1'b1;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else if (tick_en && count_one) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cancel) begin
          state_d = ST_IDLE;
          ld_fsm  = 1'b1;
        end else if (!pause && start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (cancel) begin
          state_d = ST_IDLE;
          ld_fsm  = 1'b1;
        end else if (!pause && start) begin
          ld_fsm = 1'b1;
          if (preset_zero_q) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A tens borrow means a tick hit 00; pin the count there instead of wrapping to 99.
  always_comb begin
    ld   = ld_fsm || t_borrow;
    ld_t = t_borrow ? 4'd0 : ld_t_fsm;
    ld_u = t_borrow ? 4'd0 : ld_u_fsm;
  end

  always_comb begin
    warn_d = (state_d == ST_RUN) && ({tens_nxt, units_nxt} != 8'd0) &&
             (bcd_value(tens_nxt, units_nxt) <= 7'(WARN_LIM));
  end

  bcd_digit_dec #(.RST_VAL(DEF_UNITS)) u_units (
    .clk    (clk),
    .clear_n(clear_n),
    .en     (tick_en),
    .load   (ld),
    .d      (ld_u),
    .q      (units_q),
    .nxt    (units_nxt),
    .borrow (u_borrow)
  );

  bcd_digit_dec #(.RST_VAL(DEF_TENS)) u_tens (
    .clk    (clk),
    .clear_n(clear_n),
    .en     (u_borrow),
    .load   (ld),
    .d      (ld_t),
    .q      (tens_q),
    .nxt    (tens_nxt),
    .borrow (t_borrow)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      pt_q    <= DEF_TENS;
      pu_q    <= DEF_UNITS;
      done_q  <= 1'b0;
      warn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      pu_q    <= pu_d;
      done_q  <= done_d;
      warn_q  <= warn_d;
    end
  end

  assign tens    = tens_q;
  assign units   = units_q;
  assign running = (state_q == ST_RUN);
  assign expired = (state_q == ST_DONE);
  assign done    = done_q;
  assign warn    = warn_q;

endmodule

// File: tb/tb_contador_regressivo.sv
// Self-checking bench for contador_regressivo: table of control vectors with
// expected count/flags, scoreboard queue, plus an asynchronous mid-run reset.
module tb_contador_regressivo;

  logic       clk = 1'b0;
  logic       clear_n, tick, load, start, pause, cancel;
  logic [3:0] preset_tens, preset_units, tens, units;
  logic       running, expired, done, warn;

  always #5 clk = ~clk;

  contador_regressivo #(
    .DEF_TENS (4'd3),
    .DEF_UNITS(4'd0),
    .WARN_LIM (5)
  ) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .tick        (tick),
    .load        (load),
    .preset_tens (preset_tens),
    .preset_units(preset_units),
    .start       (start),
    .pause       (pause),
    .cancel      (cancel),
    .tens        (tens),
    .units       (units),
    .running     (running),
    .expired     (expired),
    .done        (done),
    .warn        (warn)
  );

  // control bits: {cancel, pause, start, tick, load}
  localparam logic [4:0] N = 5'b00000, C = 5'b10000, P = 5'b01000,
                         S = 5'b00100, T = 5'b00010, L = 5'b00001;
  // flag bits: {running, expired, done, warn}
  localparam logic [3:0] F0 = 4'b0000, R = 4'b1000, X = 4'b0100,
                         D = 4'b0010, W = 4'b0001;

  typedef struct {
    string      nm;
    logic [4:0] ctl;
    logic [3:0] pt, pu, et, eu, ef;
  } vec_t;

  typedef struct {
    string       nm;
    logic [11:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input string nm, input logic [4:0] ctl,
                              input logic [3:0] pt, input logic [3:0] pu,
                              input logic [3:0] et, input logic [3:0] eu,
                              input logic [3:0] ef);
    tbl.push_back('{nm, ctl, pt, pu, et, eu, ef});
  endfunction

  task automatic check_now();
    sb_t         e;
    logic [11:0] act;
    act = {tens, units, running, expired, done, warn};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h required an expected entry", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got tens/units/flags %h required %h", e.nm, act, e.exp);
      end
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    {cancel, pause, start, tick, load} = v.ctl;
    preset_tens  = v.pt;
    preset_units = v.pu;
    sb.push_back('{v.nm, {v.et, v.eu, v.ef}});
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    clear_n = 1'b0;
    {cancel, pause, start, tick, load} = N;
    preset_tens  = 4'd0;
    preset_units = 4'd0;

    add("reset_idle",  N, 0, 0, 3, 0, F0);
    add("tick_idle",   T, 0, 0, 3, 0, F0);
    add("load_10",     L, 1, 0, 1, 0, F0);
    add("start_10",    S, 0, 0, 1, 0, R);
    add("borrow_09",   T, 0, 0, 0, 9, R);
    for (int i = 8; i >= 1; i--)
      add("count_down", T, 0, 0, 0, 4'(i), R | ((i <= 5) ? W : F0));
    add("expire",      T, 0, 0, 0, 0, X | D);
    add("done_1cyc",   N, 0, 0, 0, 0, X);
    add("tick_done",   T, 0, 0, 0, 0, X);
    add("pause_done",  P, 0, 0, 0, 0, X);
    add("cancel_done", C, 0, 0, 1, 0, F0);
    add("load_25",     L, 2, 5, 2, 5, F0);
    add("start_25",    S, 0, 0, 2, 5, R);
    add("pause_tick",  P | T, 0, 0, 2, 5, F0);
    add("hold_tick1",  T, 0, 0, 2, 5, F0);
    add("hold_tick2",  T, 0, 0, 2, 5, F0);
    add("resume",      S, 0, 0, 2, 5, R);
    add("tick_24",     T, 0, 0, 2, 4, R);
    add("cancel_24",   C, 0, 0, 2, 5, F0);
    add("load_15",     L, 1, 5, 1, 5, F0);
    add("start_15",    S, 0, 0, 1, 5, R);
    add("tick_14",     T, 0, 0, 1, 4, R);
    add("tick_13",     T, 0, 0, 1, 3, R);
    add("cancel_13",   C, 0, 0, 1, 5, F0);
    add("load_clamp",  L, 4'hC, 7, 9, 7, F0);
    add("start_97",    S, 0, 0, 9, 7, R);
    add("load_in_run", L, 0, 2, 9, 7, R);
    add("tick_96",     T, 0, 0, 9, 6, R);
    add("cancel_96",   C, 0, 0, 9, 7, F0);
    add("load_00",     L, 0, 0, 0, 0, F0);
    add("start_zero",  S, 0, 0, 0, 0, X | D);
    add("load_in_done", L, 0, 8, 0, 0, X);
    add("restart_zero", S, 0, 0, 0, 0, X | D);
    add("done_hold",   N, 0, 0, 0, 0, X);
    add("cancel_zero", C, 0, 0, 0, 0, F0);
    add("load_08",     L, 0, 8, 0, 8, F0);
    add("start_08",    S, 0, 0, 0, 8, R);
    for (int i = 7; i >= 1; i--)
      add("warn_window", T, 0, 0, 0, 4'(i), R | ((i <= 5) ? W : F0));
    add("expire_08",   T, 0, 0, 0, 0, X | D);
    add("restart_08",  S, 0, 0, 0, 8, R);
    add("tick_07",     T, 0, 0, 0, 7, R);

    repeat (2) @(negedge clk);
    clear_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // asynchronous reset mid-countdown, checked before the next clock edge
    @(negedge clk);
    {cancel, pause, start, tick, load} = N;
    #2 clear_n = 1'b0;
    #1;
    sb.push_back('{"async_reset", {4'd3, 4'd0, F0}});
    check_now();
    @(negedge clk);
    clear_n = 1'b1;
    v = '{"after_reset", N, 4'd0, 4'd0, 4'd3, 4'd0, F0};
    step(v);
    v = '{"start_default", S, 4'd0, 4'd0, 4'd3, 4'd0, R};
    step(v);
    v = '{"tick_default", T, 4'd0, 4'd0, 4'd2, 4'd9, R};
    step(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
